mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's load/store interface. It accepts one request at a time from the CPU datapath, inserts a fixed number of wait states, then completes the read or write against an internal word array and pulses `ready` for one cycle. It sits between the CPU's memory-address/memory-data registers and on-chip storage, and is the answering end of the handshake the CPU's control FSM initiates.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_word_array.sv | 33 +++
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;   // wide enough for WAIT_MAX

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A byte address is rejected when it is not word aligned or when it
  // points past the last word of a 2^addr_w-word array.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store handshake bundle between the CPU datapath and the memory responder.
// Latency: n/a (wires only).
// Backpressure: none; the CPU waits for ready, and busy reports an outstanding request.
// Ports: req/we/addr/wdata/be driven by the master; rdata/ready/err/busy driven by the slave.
interface mem_responder_if;
  import mem_pkg::*;

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ready, err, busy
  );

endinterface

// File: rtl/mem_word_array.sv
// Word storage: 2^ADDR_W x 32, byte-enabled synchronous write, combinational read.
// Latency: write lands on the clock edge; read is combinational on addr_i.
// Backpressure: none; always accepts a write when wr_en_i is high.
// Ports: clk_i, wr_en_i, addr_i (word index), wdata_i, be_i, rdata_o.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one load/store, waits WAIT_CYCLES, completes against on-chip words.
// Latency: ready in cycle WAIT_CYCLES+1 after the accepting edge; one request per WAIT_CYCLES+2 cycles.
// Backpressure: req is only sampled in IDLE; busy is high while a request is outstanding.
// Ports: clk, rst_n (async assert, sync release), bus (slave side of mem_responder_if).
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2   // 0..WAIT_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  // Single-stage release synchroniser: assertion is immediate, release takes
  // one edge, so the second rising edge after rst_n rises can accept a request.
  logic rst_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;

  // With WAIT_CYCLES=0 the RESP-entry edge is the accepting edge, so the
  // request fields come straight from the bus in IDLE, from the latches otherwise.
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic              cur_bad;
  logic              wr_en;
  logic [DATA_W-1:0] mem_rdata;

  assign cur_we    = (state_q == IDLE) ? bus.we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? bus.addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.wdata : wdata_q;
  assign cur_be    = (state_q == IDLE) ? bus.be    : be_q;
  assign cur_bad   = addr_bad(cur_addr, ADDR_W);

  mem_word_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (clk),
    .wr_en_i (wr_en),
    .addr_i  (cur_addr[ADDR_W+1:2]),
    .wdata_i (cur_wdata),
    .be_i    (cur_be),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          be_d    = bus.be;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Everything the response needs is decided on the RESP-entry edge:
    // the storage write and the registered ready/err/rdata.
    if (state_d == RESP && state_q != RESP) begin
      ready_d = 1'b1;
      err_d   = cur_bad;
      wr_en   = cur_we && !cur_bad && rst_sync_q;
      rdata_d = (!cur_we && !cur_bad) ? mem_rdata : '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default build (WAIT_CYCLES=2) and a WAIT_CYCLES=0 build.
// Latency: checks ready lands in cycle WAIT_CYCLES+1 after the accepting edge.
// Backpressure: checks req is ignored while busy and one ready per accepted request.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;

  always #5 clk = ~clk;

  mem_responder_if ma();
  mem_responder_if mb();

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (ma)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (mb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on DUT A, observed for six cycles after the accepting edge.
  // With toggle set, req is wiggled during the WAIT/RESP cycles.
  task automatic txn(input string tag, input logic we_v, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] b, input bit toggle,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int rdy_cyc;
    int pulses;
    logic [31:0] rd;
    logic er;
    logic busy1;
    logic busy4;
    rdy_cyc = -1;
    pulses  = 0;
    rd      = '0;
    er      = 1'b0;
    busy1   = 1'b0;
    busy4   = 1'b1;
    @(negedge clk);
    ma.req = 1'b1; ma.we = we_v; ma.addr = a; ma.wdata = wd; ma.be = b;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (ma.ready) begin
        pulses++;
        if (rdy_cyc < 0) begin
          rdy_cyc = c;
          rd = ma.rdata;
          er = ma.err;
        end
      end
      if (c == 1) busy1 = ma.busy;
      if (c == 4) busy4 = ma.busy;
      ma.req = (toggle && c <= 3) ? c[0] : 1'b0;
      ma.wdata = $urandom;
      ma.addr  = {$urandom_range(0, 255), 2'b00};
    end
    ma.req = 1'b0;
    check({tag, "_ready_cycle"}, rdy_cyc, 32'd3);
    check({tag, "_pulses"}, pulses, 32'd1);
    check({tag, "_rdata"}, rd, exp_rdata);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, "_busy_c1"}, {31'd0, busy1}, 32'd1);
    check({tag, "_busy_c4"}, {31'd0, busy4}, 32'd0);
  endtask

  initial begin
    int pulses;
    logic [7:0] rpat;
    logic [7:0] bpat;

    ma.req = 1'b0; ma.we = 1'b0; ma.addr = '0; ma.wdata = '0; ma.be = '0;
    mb.req = 1'b0; mb.we = 1'b0; mb.addr = '0; mb.wdata = '0; mb.be = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ma.ready}, 32'd0);
    check("rst_err",   {31'd0, ma.err},   32'd0);
    check("rst_busy",  {31'd0, ma.busy},  32'd0);
    check("rst_rdata", ma.rdata, 32'd0);

    // Release: req held high, acceptance only on the second edge.
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    ma.req = 1'b1; ma.we = 1'b0; ma.addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check("rel_busy_edge1", {31'd0, ma.busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rel_busy_edge2", {31'd0, ma.busy}, 32'd1);
    ma.req = 1'b0;
    repeat (5) @(negedge clk);

    // Full write then read.
    txn("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0, 1'b0);
    txn("rd10", 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 32'hDEADBEEF, 1'b0);

    // Partial write: bytes 0 and 2.
    txn("wr10p", 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, 32'h0, 1'b0);
    txn("rd10p", 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 32'hDE22BE44, 1'b0);

    // No-op write with be=0000.
    txn("wr10z", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, 1'b0);
    txn("rd10z", 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 32'hDE22BE44, 1'b0);

    // Rejected requests; the writes would alias onto word 4 if not blocked.
    txn("rd12",  1'b0, 32'h12,  32'h0, 4'b0000, 1'b0, 32'h0, 1'b1);
    txn("rd400", 1'b0, 32'h400, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1);
    txn("wr410", 1'b1, 32'h410, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0, 1'b1);
    txn("wr11",  1'b1, 32'h11,  32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0, 1'b1);
    txn("rd10e", 1'b0, 32'h10,  32'h0, 4'b0000, 1'b0, 32'hDE22BE44, 1'b0);

    // Reset in the middle of a write's WAIT.
    txn("wr20", 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    ma.req = 1'b1; ma.we = 1'b1; ma.addr = 32'h20; ma.wdata = 32'h12345678; ma.be = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    ma.req = 1'b0;
    check("mid_busy_pre", {31'd0, ma.busy}, 32'd1);
    rst_n_a = 1'b0;
    #1;
    check("mid_busy",  {31'd0, ma.busy},  32'd0);
    check("mid_ready", {31'd0, ma.ready}, 32'd0);
    check("mid_err",   {31'd0, ma.err},   32'd0);
    check("mid_rdata", ma.rdata, 32'd0);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (ma.ready) pulses++;
    end
    rst_n_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ma.ready) pulses++;
    end
    check("mid_no_ready", pulses, 32'd0);
    txn("rd20", 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 32'hCAFEF00D, 1'b0);

    // req wiggled during WAIT/RESP is ignored.
    txn("wr30t", 1'b1, 32'h30, 32'h0BADF00D, 4'b1111, 1'b1, 32'h0, 1'b0);
    txn("rd30",  1'b0, 32'h30, 32'h0, 4'b0000, 1'b0, 32'h0BADF00D, 1'b0);

    // WAIT_CYCLES=0 build: req held high, ready/busy alternate each cycle.
    @(negedge clk);
    mb.req = 1'b1; mb.we = 1'b1; mb.addr = 32'h8; mb.wdata = 32'hA5A5A5A5; mb.be = 4'b1111;
    @(posedge clk);
    rpat = '0;
    bpat = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rpat[c-1] = mb.ready;
      bpat[c-1] = mb.busy;
    end
    mb.we = 1'b0;
    check("w0_ready_pat", {24'd0, rpat}, 32'h55);
    check("w0_busy_pat",  {24'd0, bpat}, 32'h55);
    @(negedge clk);
    mb.req = 1'b0;
    check("w0_rd_ready", {31'd0, mb.ready}, 32'd1);
    check("w0_rd_rdata", mb.rdata, 32'hA5A5A5A5);
    check("w0_rd_err",   {31'd0, mb.err},   32'd0);
    @(negedge clk);
    check("w0_idle_ready", {31'd0, mb.ready}, 32'd0);
    check("w0_idle_rdata", mb.rdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
